// File: rtl/vidcnt_sched_if.sv
// Signal bundle between the video counter scheduler and its neighbours:
// video timing (vsync/de), the bus arbiter (fetch_req/fetch_ack) and the
// CPU register decode (bus_*).
interface vidcnt_sched_if #(
  parameter int AW = 21
);
  logic          vsync;
  logic          de;
  logic          fetch_ack;
  logic          bus_wr;
  logic [2:0]    bus_a;
  logic [7:0]    bus_din;
  logic [7:0]    bus_dout;
  logic [AW-1:0] vid_addr;
  logic          fetch_req;
  logic          line_active;

  // Environment side: timing generator, arbiter and CPU.
  modport master (
    output vsync, de, fetch_ack, bus_wr, bus_a, bus_din,
    input  bus_dout, vid_addr, fetch_req, line_active
  );

  // Scheduler side.
  modport slave (
    input  vsync, de, fetch_ack, bus_wr, bus_a, bus_din,
    output bus_dout, vid_addr, fetch_req, line_active
  );
endinterface

// File: rtl/vidcnt_sched.sv
// Video word-address counter scheduler.
// Holds screen base, live counter, line width and hscroll; reloads the
// counter at frame start, advances it once per granted fetch during a line
// and adds the line-width skip after each line.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | between lines, waiting for a de rise (or a latched one)
// PREFETCH | hscroll != 0: requesting the extra leading word
// FETCH    | requesting display words, one counter step per ack
// ADDLW    | one cycle, counter += linewid, then back to IDLE
//
// Counter bit n holds byte-address bit n+1, so the CPU byte lanes map as
// baseh/cnth -> [AW-1:15], basem/cntm -> [14:7], basel/cntl -> [6:0].
module vidcnt_sched #(
  parameter int AW  = 21,
  parameter int LWW = 8
) (
  input  logic            clk32,
  input  logic            reset,
  vidcnt_sched_if.slave   vif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    FETCH    = 2'd2,
    ADDLW    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           pend_q, pend_d;
  logic           armed_q, vsync_q, de_q;
  logic [AW-1:0]  base_q, base_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [LWW-1:0] lw_q, lw_d;
  logic [3:0]     hs_q, hs_d;

  logic           vsync_rise, de_rise, de_fall;
  logic           in_line, inc, add_lw;
  logic           fetch_req_c;
  logic [7:0]     dout_c;
  logic           unused_din;

  // Byte-lane bits that have no storage behind them.
  assign unused_din = ^{vif.bus_din[7:AW-15], vif.bus_din[0]};

  // Edges are only reported once the history registers hold a real
  // sample, so levels already high at reset release are not edges.
  assign vsync_rise = armed_q &  vif.vsync & ~vsync_q;
  assign de_rise    = armed_q &  vif.de    & ~de_q;
  assign de_fall    = armed_q & ~vif.de    &  de_q;

  assign in_line = (state_q == PREFETCH) || (state_q == FETCH);
  assign inc     = in_line && vif.fetch_ack;
  assign add_lw  = (state_q == ADDLW);

  // Edge-detector history registers.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      vsync_q <= vif.vsync;
      de_q    <= vif.de;
    end
  end

  // FSM state register, including the de rise latched during ADDLW.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // FSM next state; a frame event aborts any line in progress.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (de_rise || pend_q) begin
          state_d = (hs_q != 4'd0) ? PREFETCH : FETCH;
          pend_d  = 1'b0;
        end
      end
      PREFETCH: begin
        if (de_fall)            state_d = ADDLW;
        else if (vif.fetch_ack) state_d = FETCH;
      end
      FETCH: begin
        if (de_fall) state_d = ADDLW;
      end
      ADDLW: begin
        state_d = IDLE;
        pend_d  = de_rise;
      end
      default: state_d = IDLE;
    endcase
    if (vsync_rise) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end
  end

  // FSM outputs, decoded from the registered state only.
  always_comb begin
    fetch_req_c = 1'b0;
    unique case (state_q)
      PREFETCH: fetch_req_c = 1'b1;
      FETCH:    fetch_req_c = 1'b1;
      default:  fetch_req_c = 1'b0;
    endcase
  end

  assign vif.fetch_req   = fetch_req_c;
  assign vif.line_active = fetch_req_c;

  // Register and counter next values: reload beats CPU counter write
  // beats increment / line-width add.
  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    lw_d   = lw_q;
    hs_d   = hs_q;
    if (inc)    cnt_d = cnt_q + AW'(1);
    if (add_lw) cnt_d = cnt_q + AW'(lw_q);
    if (vif.bus_wr) begin
      unique case (vif.bus_a)
        3'd0: base_d[AW-1:15] = vif.bus_din[AW-16:0];
        3'd1: base_d[14:7]    = vif.bus_din;
        3'd2: base_d[6:0]     = vif.bus_din[7:1];
        3'd3: begin
          cnt_d           = cnt_q;
          cnt_d[AW-1:15]  = vif.bus_din[AW-16:0];
        end
        3'd4: begin
          cnt_d       = cnt_q;
          cnt_d[14:7] = vif.bus_din;
        end
        3'd5: begin
          cnt_d      = cnt_q;
          cnt_d[6:0] = vif.bus_din[7:1];
        end
        3'd6: lw_d = vif.bus_din[LWW-1:0];
        3'd7: hs_d = vif.bus_din[3:0];
        default: ;
      endcase
    end
    // Reload uses the base as it stood before any same-cycle write.
    if (vsync_rise) cnt_d = base_q;
  end

  // Register file and counter storage.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      cnt_q  <= '0;
      lw_q   <= '0;
      hs_q   <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
      lw_q   <= lw_d;
      hs_q   <= hs_d;
    end
  end

  // CPU read mux; unused bits read as zero.
  always_comb begin
    dout_c = 8'h00;
    unique case (vif.bus_a)
      3'd0: dout_c = 8'(base_q[AW-1:15]);
      3'd1: dout_c = base_q[14:7];
      3'd2: dout_c = {base_q[6:0], 1'b0};
      3'd3: dout_c = 8'(cnt_q[AW-1:15]);
      3'd4: dout_c = cnt_q[14:7];
      3'd5: dout_c = {cnt_q[6:0], 1'b0};
      3'd6: dout_c = 8'(lw_q);
      3'd7: dout_c = {4'h0, hs_q};
      default: dout_c = 8'h00;
    endcase
  end

  assign vif.bus_dout = dout_c;
  assign vif.vid_addr = cnt_q;

endmodule

// File: tb/tb_vidcnt_sched.sv
// Directed and randomized bench for vidcnt_sched. Expected counter values
// come from line arithmetic: start + granted words + line width, modulo
// 2^21, with CPU byte lanes viewed as a plain byte address.
module tb_vidcnt_sched;

  localparam int M = 32'h1FFFFF;

  logic clk32 = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  vidcnt_sched_if vif ();

  vidcnt_sched dut (
    .clk32 (clk32),
    .reset (reset),
    .vif   (vif)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    vif.bus_wr  = 1'b1;
    vif.bus_a   = a;
    vif.bus_din = d;
    tick();
    vif.bus_wr  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    vif.bus_a = a;
    #1;
    chk(tag, vif.bus_dout, exp);
  endtask

  // Load the counter through its byte lanes, treating it as a byte address.
  task automatic set_cnt(input int word);
    int ba;
    ba = (word & M) << 1;
    cpu_wr(3'd3, 8'((ba >> 16) & 8'hFF));
    cpu_wr(3'd4, 8'((ba >> 8) & 8'hFF));
    cpu_wr(3'd5, 8'(ba & 8'hFF));
  endtask

  // One display line: rise, n cycles of acks at pct% density, fall.
  // Returns with the ADDLW cycle pending and reports granted words.
  task automatic run_line(input int n, input int pct, input bit aof, output int acks);
    bit a;
    vif.de = 1'b1;
    vif.fetch_ack = 1'b0;
    tick();
    acks = 0;
    for (int i = 0; i < n; i++) begin
      chk("fetch_req_in_line", vif.fetch_req, 1);
      a = (int'($urandom_range(99)) < pct);
      vif.fetch_ack = a;
      tick();
      if (a) acks++;
    end
    chk("line_active_in_line", vif.line_active, 1);
    a = aof && (acks > 0);
    vif.de = 1'b0;
    vif.fetch_ack = a;
    tick();
    if (a) acks++;
    vif.fetch_ack = 1'b0;
    chk("fetch_req_addlw", vif.fetch_req, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, start, lw, hs, base, exp;

    reset = 1'b1;
    vif.vsync = 1'b0;
    vif.de = 1'b0;
    vif.fetch_ack = 1'b0;
    vif.bus_wr = 1'b0;
    vif.bus_a = 3'd0;
    vif.bus_din = 8'h00;
    repeat (3) @(posedge clk32);
    #1;
    chk("rst_vid_addr", vif.vid_addr, 0);
    chk("rst_fetch_req", vif.fetch_req, 0);
    chk("rst_line_active", vif.line_active, 0);
    for (int a = 0; a < 8; a++) rd_chk("rst_reg", 3'(a), 8'h00);
    @(negedge clk32);
    reset = 1'b0;
    tick();

    // Frame reload from base byte address 0x3F8000.
    cpu_wr(3'd0, 8'h3F);
    cpu_wr(3'd1, 8'h80);
    cpu_wr(3'd2, 8'h00);
    vif.vsync = 1'b1;
    tick();
    chk("reload_addr", vif.vid_addr, 32'h3F8000 >> 1);
    rd_chk("reload_cnth", 3'd3, 8'h3F);
    rd_chk("reload_cntm", 3'd4, 8'h80);
    rd_chk("reload_cntl", 3'd5, 8'h00);
    vif.vsync = 1'b0;
    tick();

    // Unused register bits.
    cpu_wr(3'd0, 8'hFF);
    rd_chk("baseh_mask", 3'd0, 8'h3F);
    cpu_wr(3'd2, 8'h81);
    rd_chk("basel_mask", 3'd2, 8'h80);
    cpu_wr(3'd2, 8'h00);
    cpu_wr(3'd7, 8'hF5);
    rd_chk("hscroll_mask", 3'd7, 8'h05);

    // Line without scroll.
    cpu_wr(3'd7, 8'h00);
    cpu_wr(3'd6, 8'h04);
    set_cnt(32'h100);
    chk("idle_fetch_req", vif.fetch_req, 0);
    run_line(80, 100, 1'b0, acks);
    chk("noscroll_acks", vif.vid_addr, (32'h100 + acks) & M);
    chk("noscroll_acks_80", acks, 80);
    tick();
    chk("noscroll_addlw", vif.vid_addr, 32'h154);
    chk("noscroll_idle_req", vif.fetch_req, 0);

    // Prefetch line: 81 grants including one on the falling edge.
    cpu_wr(3'd7, 8'h05);
    cpu_wr(3'd6, 8'h00);
    set_cnt(32'h1000);
    run_line(80, 100, 1'b1, acks);
    tick();
    chk("prefetch_addr", vif.vid_addr, 32'h1000 + 81);

    // Wrap on increment and on line-width add.
    cpu_wr(3'd7, 8'h00);
    set_cnt(32'h1FFFFE);
    run_line(3, 100, 1'b0, acks);
    tick();
    chk("wrap_inc", vif.vid_addr, 32'h000001);
    cpu_wr(3'd6, 8'h10);
    set_cnt(32'h1FFFF8);
    run_line(0, 100, 1'b0, acks);
    tick();
    chk("wrap_lw", vif.vid_addr, 32'h000008);

    // Back-to-back lines: de rise during the ADDLW cycle is remembered.
    cpu_wr(3'd6, 8'h03);
    set_cnt(32'h200);
    vif.de = 1'b1;
    tick();
    vif.fetch_ack = 1'b1;
    repeat (4) tick();
    vif.fetch_ack = 1'b0;
    vif.de = 1'b0;
    tick();
    chk("b2b_first", vif.vid_addr, 32'h204);
    vif.de = 1'b1;
    tick();
    chk("b2b_addlw", vif.vid_addr, 32'h207);
    chk("b2b_idle_req", vif.fetch_req, 0);
    tick();
    chk("b2b_restart_req", vif.fetch_req, 1);
    vif.fetch_ack = 1'b1;
    repeat (2) tick();
    vif.fetch_ack = 1'b0;
    vif.de = 1'b0;
    tick();
    tick();
    chk("b2b_second", vif.vid_addr, 32'h20C);

    // Counter low-byte write colliding with a grant.
    cpu_wr(3'd6, 8'h02);
    set_cnt(32'h123);
    vif.de = 1'b1;
    tick();
    vif.fetch_ack = 1'b1;
    vif.bus_wr = 1'b1;
    vif.bus_a = 3'd5;
    vif.bus_din = 8'h40;
    tick();
    vif.bus_wr = 1'b0;
    vif.fetch_ack = 1'b0;
    exp = ((((32'h123 << 1) & ~32'hFF) | 32'h40) >> 1);
    chk("cntl_collide", vif.vid_addr, exp);
    vif.de = 1'b0;
    tick();
    tick();
    chk("cntl_collide_lw", vif.vid_addr, exp + 2);

    // Base write in the same cycle as a frame event.
    vif.vsync = 1'b1;
    vif.bus_wr = 1'b1;
    vif.bus_a = 3'd1;
    vif.bus_din = 8'h12;
    tick();
    vif.bus_wr = 1'b0;
    chk("vsync_old_base", vif.vid_addr, 32'h3F8000 >> 1);
    vif.vsync = 1'b0;
    tick();
    vif.vsync = 1'b1;
    tick();
    base = 32'h3F1200 >> 1;
    chk("vsync_new_base", vif.vid_addr, base);
    vif.vsync = 1'b0;
    tick();

    // Frame event in the middle of a line.
    cpu_wr(3'd6, 8'h07);
    set_cnt(32'h500);
    vif.de = 1'b1;
    tick();
    vif.fetch_ack = 1'b1;
    repeat (5) tick();
    chk("midline_pre", vif.vid_addr, 32'h505);
    vif.vsync = 1'b1;
    tick();
    vif.fetch_ack = 1'b0;
    chk("midline_vsync_addr", vif.vid_addr, base);
    chk("midline_vsync_req", vif.fetch_req, 0);
    repeat (3) tick();
    chk("midline_still_idle", vif.fetch_req, 0);
    vif.de = 1'b0;
    repeat (2) tick();
    chk("midline_no_lw", vif.vid_addr, base);
    vif.vsync = 1'b0;
    tick();

    // Randomized lines.
    for (int k = 0; k < 24; k++) begin
      lw = int'($urandom_range(255));
      hs = int'($urandom_range(15));
      start = int'($urandom) & M;
      cpu_wr(3'd6, 8'(lw));
      cpu_wr(3'd7, 8'((int'($urandom_range(15)) << 4) | hs));
      rd_chk("rnd_hscroll", 3'd7, 8'(hs));
      set_cnt(start);
      run_line(int'($urandom_range(40)), 50, 1'($urandom_range(1)), acks);
      chk("rnd_after_acks", vif.vid_addr, (start + acks) & M);
      tick();
      chk("rnd_after_lw", vif.vid_addr, (start + acks + lw) & M);
    end

    // Reset in the middle of a line, with de held high across release.
    cpu_wr(3'd7, 8'h00);
    set_cnt(32'h777);
    vif.de = 1'b1;
    tick();
    vif.fetch_ack = 1'b1;
    repeat (2) tick();
    vif.bus_a = 3'd5;
    @(negedge clk32);
    reset = 1'b1;
    #1;
    chk("async_rst_addr", vif.vid_addr, 0);
    chk("async_rst_req", vif.fetch_req, 0);
    chk("async_rst_active", vif.line_active, 0);
    chk("async_rst_dout", vif.bus_dout, 0);
    vif.fetch_ack = 1'b0;
    @(negedge clk32);
    reset = 1'b0;
    repeat (3) tick();
    chk("release_no_edge", vif.fetch_req, 0);
    vif.de = 1'b0;
    tick();
    vif.de = 1'b1;
    tick();
    chk("post_release_line", vif.fetch_req, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
